// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the SEQ execute stage and the data-memory stage.
// Master issues one op per start pulse; slave returns done, bad_mem and the access results.
interface data_mem_unit_if #(
  parameter int DATA_W = 64
);
  logic              start;
  logic [3:0]        in_code;
  logic [DATA_W-1:0] val_e;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_p;
  logic              busy;
  logic              done;
  logic              bad_mem;
  logic [DATA_W-1:0] mem_add;
  logic [DATA_W-1:0] val_m;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output start, in_code, val_e, val_a, val_p,
    input  busy, done, bad_mem, mem_add, val_m, mem_data
  );

  modport slave (
    input  start, in_code, val_e, val_a, val_p,
    output busy, done, bad_mem, mem_add, val_m, mem_data
  );
endinterface

// File: rtl/data_mem_unit.sv
// Y86-64 data-memory stage: one op per start, LATENCY-cycle access, then a one-cycle done pulse.
// Good accesses finish LATENCY+1 cycles after accept, bad/non-memory ops after 1; start while busy is dropped.
module data_mem_unit #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input logic            clock_i,
  input logic            reset_n_i,
  data_mem_unit_if.slave bus
);
  localparam int BPW = DATA_W / 8;
  localparam int SH  = $clog2(BPW);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              wr_q;
  logic              bad_pend_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdat_q;
  logic              busy_q;
  logic              done_q;
  logic              bad_q;
  logic [DATA_W-1:0] add_q;
  logic [DATA_W-1:0] vm_q;
  logic [DATA_W-1:0] md_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              dec_mem;
  logic              dec_wr;
  logic [DATA_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_wdat;
  logic [DATA_W-1:0] idx_full;
  logic              dec_bad;
  logic              acc_now;

  always_comb begin
    dec_mem  = 1'b1;
    dec_wr   = 1'b0;
    dec_addr = bus.val_e;
    dec_wdat = bus.val_a;
    case (bus.in_code)
      4'd4:    dec_wr = 1'b1;
      4'd5:    dec_wr = 1'b0;
      4'd8: begin
        dec_wr   = 1'b1;
        dec_wdat = bus.val_p;
      end
      4'd9:    dec_addr = bus.val_a;
      4'd10:   dec_wr = 1'b1;
      4'd11:   dec_addr = bus.val_a;
      default: dec_mem = 1'b0;
    endcase
  end

  // Range check uses the full shifted address so high garbage bits are caught too.
  assign idx_full = dec_addr >> SH;
  assign dec_bad  = dec_mem & ((|dec_addr[SH-1:0]) | (idx_full >= DATA_W'(DEPTH)));
  assign acc_now  = (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      bad_pend_q <= 1'b0;
      idx_q      <= '0;
      wdat_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      add_q      <= '0;
      vm_q       <= '0;
      md_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q     <= 1'b1;
            bad_q      <= 1'b0;
            add_q      <= dec_addr;
            wr_q       <= dec_wr;
            idx_q      <= dec_addr[SH +: AW];
            wdat_q     <= dec_wdat;
            bad_pend_q <= dec_bad;
            cnt_q      <= CW'(LATENCY - 1);
            state_q    <= (dec_mem && !dec_bad) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            if (wr_q) begin
              md_q <= wdat_q;
            end else begin
              vm_q <= mem[idx_q];
              md_q <= mem[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          bad_q   <= bad_pend_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array is not reset; an async reset during WAIT drops state_q and so suppresses the write.
  always_ff @(posedge clock_i) begin
    if (acc_now && wr_q) begin
      mem[idx_q] <= wdat_q;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bad_mem  = bad_q;
  assign bus.mem_add  = add_q;
  assign bus.val_m    = vm_q;
  assign bus.mem_data = md_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: one LATENCY=1 instance and one LATENCY=4 instance.
module tb_data_mem_unit;
  localparam int DW    = 64;
  localparam int DEPTH = 1024;

  typedef struct {
    logic        bad;
    logic [63:0] add;
    logic [63:0] vm;
    logic [63:0] md;
    int          lat;
  } exp_t;

  typedef struct {
    logic        busy;
    logic        done;
    logic        bad;
    logic [63:0] add;
    logic [63:0] vm;
    logic [63:0] md;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_unit_if #(.DATA_W(DW)) bus_a ();
  data_mem_unit_if #(.DATA_W(DW)) bus_b ();

  data_mem_unit #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(1)) dut_a (
    .clock_i(clk), .reset_n_i(rst_n), .bus(bus_a));
  data_mem_unit #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(4)) dut_b (
    .clock_i(clk), .reset_n_i(rst_n), .bus(bus_b));

  int   n_tot = 0;
  int   n_bad = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [3:0] c,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
    if (sel) begin
      bus_b.start = s; bus_b.in_code = c; bus_b.val_e = e; bus_b.val_a = a; bus_b.val_p = p;
    end else begin
      bus_a.start = s; bus_a.in_code = c; bus_a.val_e = e; bus_a.val_a = a; bus_a.val_p = p;
    end
  endtask

  function automatic obs_t snap(input bit sel);
    obs_t o;
    if (sel) begin
      o.busy = bus_b.busy; o.done = bus_b.done; o.bad = bus_b.bad_mem;
      o.add = bus_b.mem_add; o.vm = bus_b.val_m; o.md = bus_b.mem_data;
    end else begin
      o.busy = bus_a.busy; o.done = bus_a.done; o.bad = bus_a.bad_mem;
      o.add = bus_a.mem_add; o.vm = bus_a.val_m; o.md = bus_a.mem_data;
    end
    return o;
  endfunction

  // Issue one op, then wait (bounded) for done and compare against the queued expectation.
  task automatic run_op(input string tag, input bit sel, input logic [3:0] code,
                        input logic [63:0] e, input logic [63:0] a, input logic [63:0] p,
                        input logic xbad, input logic [63:0] xadd, input logic [63:0] xvm,
                        input logic [63:0] xmd, input int xlat, input bit restart);
    exp_t x;
    obs_t o;
    int   n = 0;
    int   busy_cnt;
    int   extra = 0;
    bit   got = 1'b0;
    x.bad = xbad; x.add = xadd; x.vm = xvm; x.md = xmd; x.lat = xlat;
    sb.push_back(x);
    @(negedge clk);
    drive(sel, 1'b1, code, e, a, p);
    @(posedge clk);
    #1 drive(sel, 1'b0, 4'd0, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    o = snap(sel);
    busy_cnt = int'(o.busy);
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      o = snap(sel);
      if (o.done) begin
        got = 1'b1;
        break;
      end
      busy_cnt += int'(o.busy);
      if (restart && n == 2) drive(sel, 1'b1, 4'd5, 64'h10, 64'h0, 64'h0);
      if (restart && n == 3) drive(sel, 1'b0, 4'd0, 64'h0, 64'h0, 64'h0);
    end
    x = sb.pop_front();
    chk({tag, ".done_seen"}, 64'(got), 64'd1);
    chk({tag, ".latency"}, 64'(n), 64'(x.lat));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(x.lat));
    chk({tag, ".busy_at_done"}, 64'(o.busy), 64'd0);
    chk({tag, ".bad_mem"}, 64'(o.bad), 64'(x.bad));
    chk({tag, ".mem_add"}, o.add, x.add);
    chk({tag, ".val_m"}, o.vm, x.vm);
    chk({tag, ".mem_data"}, o.md, x.md);
    repeat (6) begin
      @(negedge clk);
      o = snap(sel);
      extra += int'(o.done);
    end
    chk({tag, ".single_done"}, 64'(extra), 64'd0);
    chk({tag, ".bad_held"}, 64'(o.bad), 64'(x.bad));
  endtask

  initial begin
    obs_t o;
    int   dcnt;
    drive(1'b0, 1'b0, 4'd0, 64'h0, 64'h0, 64'h0);
    drive(1'b1, 1'b0, 4'd0, 64'h0, 64'h0, 64'h0);
    repeat (3) @(negedge clk);
    o = snap(1'b0);
    chk("rst.busy", 64'(o.busy), 64'd0);
    chk("rst.done", 64'(o.done), 64'd0);
    chk("rst.bad", 64'(o.bad), 64'd0);
    chk("rst.add", o.add, 64'h0);
    chk("rst.vm", o.vm, 64'h0);
    chk("rst.md", o.md, 64'h0);
    rst_n = 1'b1;

    run_op("wr10",    0, 4'd4,  64'h10,   64'hDEAD, 64'h0,  0, 64'h10,   64'h0,    64'hDEAD, 2, 0);
    run_op("rd10",    0, 4'd5,  64'h10,   64'h0,    64'h0,  0, 64'h10,   64'hDEAD, 64'hDEAD, 2, 0);
    run_op("call",    0, 4'd8,  64'h1F8,  64'h99,   64'h40, 0, 64'h1F8,  64'hDEAD, 64'h40,   2, 0);
    run_op("ret",     0, 4'd9,  64'h10,   64'h1F8,  64'h0,  0, 64'h1F8,  64'h40,   64'h40,   2, 0);
    run_op("misal",   0, 4'd5,  64'h13,   64'h0,    64'h0,  1, 64'h13,   64'h40,   64'h40,   1, 0);
    run_op("wrtop",   0, 4'd4,  64'h1FF8, 64'h1234, 64'h0,  0, 64'h1FF8, 64'h40,   64'h1234, 2, 0);
    run_op("range",   0, 4'd4,  64'h2000, 64'hBAD,  64'h0,  1, 64'h2000, 64'h40,   64'h1234, 1, 0);
    run_op("hibits",  0, 4'd4,  64'h8000_0000_0000_0010, 64'hBAD, 64'h0,
           1, 64'h8000_0000_0000_0010, 64'h40, 64'h1234, 1, 0);
    run_op("rdtop",   0, 4'd5,  64'h1FF8, 64'h0,    64'h0,  0, 64'h1FF8, 64'h1234, 64'h1234, 2, 0);
    run_op("push",    0, 4'd10, 64'h30,   64'h77,   64'h0,  0, 64'h30,   64'h1234, 64'h77,   2, 0);
    run_op("pop",     0, 4'd11, 64'h0,    64'h30,   64'h0,  0, 64'h30,   64'h77,   64'h77,   2, 0);
    run_op("nop",     0, 4'd0,  64'h48,   64'h0,    64'h0,  0, 64'h48,   64'h77,   64'h77,   1, 0);
    run_op("wr20",    0, 4'd4,  64'h20,   64'h1111, 64'h0,  0, 64'h20,   64'h77,   64'h1111, 2, 0);

    // Reset while a write to 0x20 sits in WAIT.
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd4, 64'h20, 64'h2222, 64'h0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 4'd0, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 o = snap(1'b0);
    chk("midrst.busy", 64'(o.busy), 64'd0);
    chk("midrst.add", o.add, 64'h0);
    chk("midrst.vm", o.vm, 64'h0);
    chk("midrst.md", o.md, 64'h0);
    dcnt = 0;
    repeat (2) begin
      @(negedge clk);
      dcnt += int'(bus_a.done);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      dcnt += int'(bus_a.done);
    end
    chk("midrst.no_done", 64'(dcnt), 64'd0);
    run_op("rd20",    0, 4'd5,  64'h20,   64'h0,    64'h0,  0, 64'h20,   64'h1111, 64'h1111, 2, 0);

    run_op("b_wr",    1, 4'd4,  64'h10,   64'h55,   64'h0,  0, 64'h10,   64'h0,    64'h55,   5, 1);
    run_op("b_rd",    1, 4'd5,  64'h10,   64'h0,    64'h0,  0, 64'h10,   64'h55,   64'h55,   5, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
